// File: rtl/sram_march_bist.sv
// -----------------------------------------------------------------------------
// sram_march_bist
//   March C- self-test controller for a single-port SRAM. While busy it owns
//   the SRAM write enable, address and write data, walks every address through
//   six march elements and checks every read against the expected background.
//   The first mismatch ends the test and its address/element are latched.
//
//   Elements: M0 up(w0)  M1 up(r0,w1)  M2 up(r1,w0)
//             M3 down(r0,w1)  M4 down(r1,w0)  M5 up(r0)
//
// Ports
//   clk        clock, all logic on posedge
//   rst        synchronous active-high reset
//   start      begin a test (only honoured in IDLE or DONE)
//   busy       high while the test is running
//   done       one-cycle pulse when the test ends
//   pass       result, valid from done until the next start/rst
//   fail_addr  address of the first mismatch (0 on pass)
//   fail_elem  march element of the first mismatch (0 on pass)
//   mem_wren   SRAM write enable
//   mem_addr   SRAM address
//   mem_din    SRAM write data
//   mem_dout   SRAM read data, valid RD_LAT cycles after the read is issued
// -----------------------------------------------------------------------------
module sram_march_bist #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [2:0]        fail_elem,
    output logic              mem_wren,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout
);

    typedef enum logic [2:0] {
        S_IDLE, S_WRITE, S_RD_ISSUE, S_RD_WAIT, S_RD_CMP, S_DONE
    } state_t;

    localparam logic [ADDR_W-1:0] ADDR_MAX  = {ADDR_W{1'b1}};
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
    localparam logic [2:0]        LAST_ELEM = 3'd5;
    localparam int                WAIT_W    = (RD_LAT > 2) ? $clog2(RD_LAT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((RD_LAT > 1) ? RD_LAT - 2 : 0);

    // M3 and M4 sweep downwards, all other elements upwards.
    function automatic logic elem_down(input logic [2:0] e);
        return (e == 3'd3) || (e == 3'd4);
    endfunction

    // M0 is a lone write, M5 a lone read; M1..M4 are read (op 0) then write (op 1).
    function automatic logic op_is_read(input logic [2:0] e, input logic op);
        case (e)
            3'd0:    return 1'b0;
            3'd5:    return 1'b1;
            default: return !op;
        endcase
    endfunction

    function automatic logic op_is_last(input logic [2:0] e, input logic op);
        return (e == 3'd0) || (e == LAST_ELEM) || op;
    endfunction

    // Background bit for the current op: M1/M3 read 0 then write 1,
    // M2/M4 read 1 then write 0, M0/M5 use 0.
    function automatic logic op_pattern(input logic [2:0] e, input logic op);
        case (e)
            3'd1, 3'd3: return op;
            3'd2, 3'd4: return !op;
            default:    return 1'b0;
        endcase
    endfunction

    state_t              state, state_n;
    logic [2:0]          elem, elem_n;
    logic                op, op_n;
    logic [ADDR_W-1:0]   addr, addr_n;
    logic [WAIT_W-1:0]   wait_cnt, wait_n;
    logic                cur_pat;
    logic                start_ok;
    logic                cmp_fail;
    logic                advance;
    logic                test_end;

    // State register plus sequence counters and latched result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            elem      <= '0;
            op        <= 1'b0;
            addr      <= '0;
            wait_cnt  <= '0;
            done      <= 1'b0;
            pass      <= 1'b0;
            fail_addr <= '0;
            fail_elem <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values regardless of statement order.
            state    <= state_n;
            elem     <= elem_n;
            op       <= op_n;
            addr     <= addr_n;
            wait_cnt <= wait_n;
            done     <= busy && (state_n == S_DONE);
            if (start_ok) begin
                pass      <= 1'b0;
                fail_addr <= '0;
                fail_elem <= '0;
            end else if (cmp_fail) begin
                pass      <= 1'b0;
                fail_addr <= addr;
                fail_elem <= elem;
            end else if (busy && state_n == S_DONE) begin
                pass <= 1'b1;
            end
        end
    end

    // Next-state and counter sequencing.
    always_comb begin
        // NOTE: every variable gets a default first so no path infers a latch.
        state_n  = state;
        elem_n   = elem;
        op_n     = op;
        addr_n   = addr;
        wait_n   = wait_cnt;
        start_ok = 1'b0;
        cmp_fail = 1'b0;
        advance  = 1'b0;
        test_end = 1'b0;
        cur_pat  = op_pattern(elem, op);

        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    start_ok = 1'b1;
                    state_n  = S_WRITE;
                    elem_n   = '0;
                    op_n     = 1'b0;
                    addr_n   = '0;
                end
            end
            S_WRITE:    advance = 1'b1;
            S_RD_ISSUE: begin
                wait_n  = '0;
                state_n = (RD_LAT == 1) ? S_RD_CMP : S_RD_WAIT;
            end
            S_RD_WAIT: begin
                if (wait_cnt == WAIT_LAST) state_n = S_RD_CMP;
                else                       wait_n  = wait_cnt + WAIT_W'(1);
            end
            S_RD_CMP: begin
                // Case inequality so X/Z on the read data counts as a fault.
                if (mem_dout !== {DATA_W{cur_pat}}) begin
                    cmp_fail = 1'b1;
                    state_n  = S_DONE;
                end else begin
                    advance = 1'b1;
                end
            end
            default: state_n = S_IDLE;
        endcase

        if (advance) begin
            if (!op_is_last(elem, op)) begin
                op_n = 1'b1;
            end else begin
                op_n = 1'b0;
                if (addr != (elem_down(elem) ? '0 : ADDR_MAX)) begin
                    addr_n = elem_down(elem) ? addr - ADDR_ONE : addr + ADDR_ONE;
                end else if (elem == LAST_ELEM) begin
                    test_end = 1'b1;
                end else begin
                    // Element boundary: the next sweep starts from its own end.
                    elem_n = elem + 3'd1;
                    addr_n = elem_down(elem + 3'd1) ? ADDR_MAX : '0;
                end
            end
            if (test_end)                     state_n = S_DONE;
            else if (op_is_read(elem_n, op_n)) state_n = S_RD_ISSUE;
            else                              state_n = S_WRITE;
        end
    end

    // Outputs decoded from the current state.
    always_comb begin
        busy     = (state != S_IDLE) && (state != S_DONE);
        mem_wren = (state == S_WRITE);
        mem_addr = addr;
        mem_din  = (state == S_WRITE) ? {DATA_W{cur_pat}} : '0;
    end

endmodule
